uart_byte_fifo: RTL and testbench

UART_BYTE_FIFO -- requirements
Module: uart_byte_fifo

---
 rtl/uart_byte_fifo.sv | 102 ++++++++++
 tb/tb_uart_byte_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx: first-word-fall-through, sticky overflow.
// Optional drop counter enabled by defining UART_FIFO_DROP_CNT_EN.
module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  input  logic                  ovf_clr
`ifdef UART_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int Depth = 2 ** DEPTH_LOG2;

  logic [7:0]          mem_q [Depth];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                empty, full;
  logic                push, pop, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0])
              && (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign level     = level_q;
  assign ovf       = ovf_q;

  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;
  assign drop = in_valid & full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      push && !pop: level_d = level_q + 1'b1;
      pop && !push: level_d = level_q - 1'b1;
      default:      level_d = level_q;
    endcase
    // a new overflow beats a simultaneous clear
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef UART_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt = drop_cnt_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Scoreboard bench for uart_byte_fifo (DEPTH_LOG2=4).
// A reference model queues accepted bytes; a negedge monitor checks outputs.
module tb_uart_byte_fifo;

  localparam int DL = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DL:0]   level;
  logic          ovf;
  logic          ovf_clr = 1'b0;
`ifdef UART_FIFO_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  uart_byte_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef UART_FIFO_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [7:0] q[$];
  int         mcount = 0;
  logic       movf = 1'b0;
  int         mdrop = 0;
  bit         m_pu, m_po, m_dr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model, evaluated on the same edge the DUT uses
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcount = 0;
      q.delete();
      movf   = 1'b0;
      mdrop  = 0;
    end else begin
      m_pu = in_valid && (mcount < D);
      m_po = out_ready && (mcount > 0);
      m_dr = in_valid && (mcount == D);
      if (m_pu) q.push_back(in_data);
      mcount = mcount + int'(m_pu) - int'(m_po);
      if (m_dr) movf = 1'b1;
      else if (ovf_clr) movf = 1'b0;
      if (m_dr) begin
        if (mdrop < 255) mdrop++;
      end else if (ovf_clr) begin
        mdrop = 0;
      end
    end
  end

  // monitor: compares status every cycle and the head byte on each pop
  always @(negedge clk) begin
    if (rst_n) begin
      chk("level", 32'(level), mcount);
      chk("out_valid", 32'(out_valid), 32'(mcount != 0));
      chk("in_ready", 32'(in_ready), 32'(mcount != D));
      chk("ovf", 32'(ovf), 32'(movf));
`ifdef UART_FIFO_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), mdrop);
`endif
      if (out_ready && mcount > 0) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL scoreboard: pop with empty queue at %0t", $time);
        end else begin
          chk("out_data", 32'(out_data), 32'(q.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 64 && mcount != 0; i++) step();
    chk("drain_done", mcount, 0);
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;

    // pop request on empty FIFO must be ignored
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;

    // single byte fall-through
    push(8'h41);
    chk("one_valid", 32'(out_valid), 1);
    chk("one_data", 32'(out_data), 32'h41);
    chk("one_level", 32'(level), 1);
    chk("one_ready", 32'(in_ready), 1);
    step();
    chk("one_hold", 32'(out_data), 32'h41);
    drain();

    // fill completely then drain in order
    for (int i = 0; i < D; i++) push(8'(i));
    chk("full_level", 32'(level), 16);
    chk("full_ready", 32'(in_ready), 0);
    drain();
    chk("empty_valid", 32'(out_valid), 0);

    // overflow while full, then set/clear collision, then clear
    for (int i = 0; i < D; i++) push(8'(8'h80 + i));
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    chk("ovf_set", 32'(ovf), 1);
`ifdef UART_FIFO_DROP_CNT_EN
    chk("drop3", 32'(drop_cnt), 3);
`endif
    in_valid = 1'b1;
    ovf_clr  = 1'b1;
    step();
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);
`ifdef UART_FIFO_DROP_CNT_EN
    chk("drop_cleared", 32'(drop_cnt), 0);
`endif
    drain();

    // steady push+pop at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'(8'hC5 + i);
      step();
      chk("stream_level", 32'(level), 5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drain();

    // asynchronous reset mid-cycle with data buffered
    for (int i = 0; i < 7; i++) push(8'(8'h30 + i));
    chk("pre_rst_level", 32'(level), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_ovf", 32'(ovf), 0);
    step();
    rst_n = 1'b1;
    step();
    push(8'h55);
    chk("post_rst_head", 32'(out_data), 32'h55);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

endmodule
